// File: rtl/fft_iter_r2_if.sv
// Stream bundle for the iterative radix-2 FFT engine: sample input, result output and status.
// The master side is the host; the slave side is the engine.
interface fft_iter_r2_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;
  logic              in_valid;
  logic              in_ready;
  logic              scale_en;
  logic [DATA_W-1:0] out_real;
  logic [DATA_W-1:0] out_imag;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              overflow;
  logic              busy;

  modport master (
    output in_real, in_imag, in_valid, scale_en, out_ready,
    input  in_ready, out_real, out_imag, out_valid, out_last, overflow, busy
  );

  modport slave (
    input  in_real, in_imag, in_valid, scale_en, out_ready,
    output in_ready, out_real, out_imag, out_valid, out_last, overflow, busy
  );
endinterface

// File: rtl/fft_iter_r2.sv
// Iterative radix-2 DIT complex FFT: bit-reversed load, LOG2N in-place stages through one
// time-shared butterfly, natural-order unload with optional per-stage halving.
module fft_iter_r2 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2N  = 3,
  parameter int unsigned TW_W   = 16
) (
  input logic        clk,
  input logic        reset,
  fft_iter_r2_if.slave link
);
  localparam int unsigned N   = 1 << LOG2N;
  localparam int unsigned AW  = LOG2N;
  localparam int unsigned SW  = DATA_W + 1;
  localparam int unsigned WW  = DATA_W + 2;
  localparam int unsigned ACW = DATA_W + TW_W + 1;

  typedef logic [N/2-1:0][TW_W-1:0] tw_tab_t;
  typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

  // Series evaluation keeps the twiddle table independent of tool math builtins.
  function automatic real taylor(real x, bit is_cos);
    real term;
    real sum;
    int  k0;
    sum  = 0.0;
    term = is_cos ? 1.0 : x;
    k0   = is_cos ? 0 : 1;
    for (int k = 0; k < 40; k++) begin
      sum  = sum + term;
      term = -term * x * x / real'((2 * k + k0 + 1) * (2 * k + k0 + 2));
    end
    return sum;
  endfunction

  function automatic logic [TW_W-1:0] to_q(real v);
    real    sc;
    longint r;
    longint lim;
    sc = v;
    for (int i = 0; i < int'(TW_W) - 1; i++) sc = sc * 2.0;
    r   = (sc >= 0.0) ? longint'($rtoi(sc + 0.5)) : -longint'($rtoi(-sc + 0.5));
    lim = (longint'(1) << (TW_W - 1)) - 1;
    if (r > lim) r = lim;
    if (r < -lim - 1) r = -lim - 1;
    return r[TW_W-1:0];
  endfunction

  function automatic tw_tab_t gen_tw(bit is_re);
    tw_tab_t tab;
    real     ang;
    for (int t = 0; t < int'(N / 2); t++) begin
      ang    = 2.0 * 3.14159265358979323846 * real'(t) / real'(N);
      tab[t] = is_re ? to_q(taylor(ang, 1'b1)) : to_q(-taylor(ang, 1'b0));
    end
    return tab;
  endfunction

  localparam tw_tab_t TwRe = gen_tw(1'b1);
  localparam tw_tab_t TwIm = gen_tw(1'b0);
  localparam logic signed [ACW-1:0] Rnd = ACW'(longint'(1) << (TW_W - 2));

  function automatic logic [AW-1:0] bitrev(logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < int'(AW); i++) r[i] = v[int'(AW) - 1 - i];
    return r;
  endfunction

  // Returns {wrapped, value}; wrapped flags a result not representable in DATA_W bits.
  function automatic logic [DATA_W:0] fit(logic signed [WW-1:0] v, logic sc);
    logic signed [WW-1:0] sel;
    logic                 ok;
    sel = sc ? (v >>> 1) : v;
    ok  = (&sel[WW-1:DATA_W-1]) | ~(|sel[WW-1:DATA_W-1]);
    return {~ok, sel[DATA_W-1:0]};
  endfunction

  state_e        state_q;
  logic [AW-1:0] idx_q, k_q, b_q, s_q;
  logic          scale_q, sticky_q;
  logic          in_ready_q, out_valid_q, out_last_q, overflow_q, busy_q;

  logic signed [DATA_W-1:0] mem_re [N];
  logic signed [DATA_W-1:0] mem_im [N];

  logic                     load_fire;
  logic [AW-1:0]            mask, lo, p, q, t;
  logic [AW-2:0]            t_sel;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [ACW-1:0]    acc_re, acc_im, mul_re, mul_im;
  logic signed [SW-1:0]     tb_re, tb_im;
  logic signed [WW-1:0]     s0_re, s0_im, s1_re, s1_im;
  logic [DATA_W:0]          r0_re, r0_im, r1_re, r1_im;
  logic                     ovf_now;

  assign load_fire = (state_q == StLoad) & in_ready_q & link.in_valid;

  always_comb begin
    mask  = ~({AW{1'b1}} << s_q);
    lo    = b_q & mask;
    p     = ((b_q & ~mask) << 1) | lo;
    q     = p | (AW'(1) << s_q);
    t     = lo << (AW'(AW - 1) - s_q);
    t_sel = t[AW-2:0];

    a_re = mem_re[p];
    a_im = mem_im[p];
    b_re = mem_re[q];
    b_im = mem_im[q];
    w_re = $signed(TwRe[t_sel]);
    w_im = $signed(TwIm[t_sel]);

    acc_re = ACW'(b_re) * ACW'(w_re) - ACW'(b_im) * ACW'(w_im) + Rnd;
    acc_im = ACW'(b_re) * ACW'(w_im) + ACW'(b_im) * ACW'(w_re) + Rnd;
    mul_re = acc_re >>> (TW_W - 1);
    mul_im = acc_im >>> (TW_W - 1);

    // W^0 and W^(N/4) are exact, so they skip the rounding multiplier.
    if (t == '0) begin
      tb_re = SW'(b_re);
      tb_im = SW'(b_im);
    end else if (t == AW'(N / 4)) begin
      tb_re = SW'(b_im);
      tb_im = -(SW'(b_re));
    end else begin
      tb_re = mul_re[SW-1:0];
      tb_im = mul_im[SW-1:0];
    end

    s0_re = WW'(a_re) + WW'(tb_re);
    s0_im = WW'(a_im) + WW'(tb_im);
    s1_re = WW'(a_re) - WW'(tb_re);
    s1_im = WW'(a_im) - WW'(tb_im);

    r0_re   = fit(s0_re, scale_q);
    r0_im   = fit(s0_im, scale_q);
    r1_re   = fit(s1_re, scale_q);
    r1_im   = fit(s1_im, scale_q);
    ovf_now = r0_re[DATA_W] | r0_im[DATA_W] | r1_re[DATA_W] | r1_im[DATA_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (load_fire) begin
        mem_re[bitrev(idx_q)] <= link.in_real;
        mem_im[bitrev(idx_q)] <= link.in_imag;
      end else if (state_q == StCompute) begin
        mem_re[p] <= r0_re[DATA_W-1:0];
        mem_im[p] <= r0_im[DATA_W-1:0];
        mem_re[q] <= r1_re[DATA_W-1:0];
        mem_im[q] <= r1_im[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StLoad;
      idx_q       <= '0;
      k_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      scale_q     <= 1'b0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          in_ready_q <= 1'b1;
          if (load_fire) begin
            if (idx_q == '0) scale_q <= link.scale_en;
            if (idx_q == AW'(N - 1)) begin
              idx_q      <= '0;
              b_q        <= '0;
              s_q        <= '0;
              sticky_q   <= 1'b0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= StCompute;
            end else begin
              idx_q <= idx_q + AW'(1);
            end
          end
        end
        StCompute: begin
          sticky_q <= sticky_q | ovf_now;
          if (b_q == AW'(N / 2 - 1)) begin
            b_q <= '0;
            if (s_q == AW'(LOG2N - 1)) begin
              k_q         <= '0;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              overflow_q  <= sticky_q | ovf_now;
              state_q     <= StUnload;
            end else begin
              s_q <= s_q + AW'(1);
            end
          end else begin
            b_q <= b_q + AW'(1);
          end
        end
        StUnload: begin
          if (link.out_ready) begin
            if (k_q == AW'(N - 1)) begin
              k_q         <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= StLoad;
            end else begin
              k_q        <= k_q + AW'(1);
              out_last_q <= (k_q == AW'(N - 2));
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign link.in_ready  = in_ready_q;
  assign link.out_valid = out_valid_q;
  assign link.out_last  = out_last_q;
  assign link.overflow  = overflow_q;
  assign link.busy      = busy_q;
  assign link.out_real  = out_valid_q ? mem_re[k_q] : '0;
  assign link.out_imag  = out_valid_q ? mem_im[k_q] : '0;
endmodule

// File: tb/tb_fft_iter_r2.sv
// Randomised and directed bench for fft_iter_r2 against a textbook fixed-point DIT FFT model.
module tb_fft_iter_r2;
  localparam int DATA_W = 16;
  localparam int LOG2N  = 3;
  localparam int TW_W   = 16;
  localparam int N      = 1 << LOG2N;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_iter_r2_if #(.DATA_W(DATA_W)) link ();

  fft_iter_r2 #(.DATA_W(DATA_W), .LOG2N(LOG2N), .TW_W(TW_W)) dut (
    .clk  (clk),
    .reset(reset),
    .link (link)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int xr[N], xi[N], er[N], ei[N];
  int eovf;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(longint v, int bits);
    longint m;
    m = v & ((longint'(1) << bits) - 1);
    if (m >= (longint'(1) << (bits - 1))) m = m - (longint'(1) << bits);
    return m;
  endfunction

  function automatic int brev(int i);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if (((i >> b) & 1) != 0) r |= 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  function automatic longint rnd(real x);
    return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(-x + 0.5));
  endfunction

  // Reduces one butterfly sum to an output sample, flagging any wrap.
  function automatic longint squash(longint v, bit sc, inout int ovf);
    longint w, r;
    w = sc ? (v >>> 1) : v;
    r = sx(w, DATA_W);
    if (r != w) ovf = 1;
    return r;
  endfunction

  task automatic model(input bit sc);
    longint ar[N], ai[N];
    longint br, bi, tr, ti, wr, wi, a0r, a0i;
    real    ang, qs;
    int     ovf = 0;
    qs = real'(longint'(1) << (TW_W - 1));
    for (int i = 0; i < N; i++) begin
      ar[brev(i)] = xr[i];
      ai[brev(i)] = xi[i];
    end
    for (int s = 0; s < LOG2N; s++) begin
      int h = 1 << s;
      for (int g = 0; g < N; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          int tw = j * (N / (2 * h));
          a0r = ar[g + j];
          a0i = ai[g + j];
          br  = ar[g + j + h];
          bi  = ai[g + j + h];
          if (tw == 0) begin
            tr = br;
            ti = bi;
          end else if (tw == N / 4) begin
            tr = bi;
            ti = -br;
          end else begin
            ang = 2.0 * 3.141592653589793 * real'(tw) / real'(N);
            wr  = rnd($cos(ang) * qs);
            wi  = rnd(-$sin(ang) * qs);
            tr  = sx((br * wr - bi * wi + (longint'(1) << (TW_W - 2))) >>> (TW_W - 1), DATA_W + 1);
            ti  = sx((br * wi + bi * wr + (longint'(1) << (TW_W - 2))) >>> (TW_W - 1), DATA_W + 1);
          end
          ar[g + j]     = squash(a0r + tr, sc, ovf);
          ai[g + j]     = squash(a0i + ti, sc, ovf);
          ar[g + j + h] = squash(a0r - tr, sc, ovf);
          ai[g + j + h] = squash(a0i - ti, sc, ovf);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      er[i] = int'(ar[i]);
      ei[i] = int'(ai[i]);
    end
    eovf = ovf;
  endtask

  task automatic send_frame(input bit sc, input bit hold);
    for (int i = 0; i < N; i++) begin
      int guard = 0;
      link.in_real  = DATA_W'(xr[i]);
      link.in_imag  = DATA_W'(xi[i]);
      link.in_valid = 1'b1;
      link.scale_en = (i == 0) ? sc : 1'($urandom_range(0, 1));
      while (!link.in_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 50) begin
        check("in_ready_timeout", 0, 1);
        link.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    link.in_valid = hold;
    link.in_real  = DATA_W'($urandom);
    link.in_imag  = DATA_W'($urandom);
    link.scale_en = 1'($urandom_range(0, 1));
  endtask

  // mode 0: always ready, 1: ready every third cycle, 2: random ready.
  task automatic recv_frame(input int mode, input string tag);
    int n = 0;
    int k = 0;
    int cyc = 0;
    bit rdy;
    while (!link.out_valid && n < 100) begin
      if (n == 0) begin
        check({tag, "_busy"}, int'(link.busy), 1);
        check({tag, "_inrdy_cmp"}, int'(link.in_ready), 0);
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, LOG2N * N / 2);
    check({tag, "_ovf"}, int'(link.overflow), eovf);
    while (k < N && cyc < 400) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      link.out_ready = rdy;
      check($sformatf("%s_valid%0d", tag, k), int'(link.out_valid), 1);
      if (link.out_valid) begin
        check($sformatf("%s_re%0d", tag, k), int'($signed(link.out_real)), er[k]);
        check($sformatf("%s_im%0d", tag, k), int'($signed(link.out_imag)), ei[k]);
        check($sformatf("%s_last%0d", tag, k), int'(link.out_last), (k == N - 1) ? 1 : 0);
        if (rdy) k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (k < N) check({tag, "_unload_timeout"}, k, N);
    link.out_ready = 1'b0;
    link.in_valid  = 1'b0;
    check({tag, "_valid_end"}, int'(link.out_valid), 0);
    check({tag, "_inrdy_end"}, int'(link.in_ready), 1);
    check({tag, "_busy_end"}, int'(link.busy), 0);
  endtask

  task automatic do_frame(input bit sc, input bit hold, input int mode, input string tag);
    model(sc);
    send_frame(sc, hold);
    recv_frame(mode, tag);
  endtask

  task automatic fill(input int r0, input int i0, input int rr, input int ri);
    for (int i = 0; i < N; i++) begin
      xr[i] = rr;
      xi[i] = ri;
    end
    xr[0] = r0;
    xi[0] = i0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    link.in_real   = '0;
    link.in_imag   = '0;
    link.in_valid  = 1'b0;
    link.scale_en  = 1'b0;
    link.out_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(link.out_valid), 0);
    check("rst_last", int'(link.out_last), 0);
    check("rst_ovf", int'(link.overflow), 0);
    check("rst_busy", int'(link.busy), 0);
    check("rst_real", int'(link.out_real), 0);
    check("rst_imag", int'(link.out_imag), 0);
    check("rst_inrdy", int'(link.in_ready), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_inrdy_next", int'(link.in_ready), 1);

    fill(1000, 0, 0, 0);
    do_frame(1'b0, 1'b0, 0, "impulse");
    fill(100, 0, 100, 0);
    do_frame(1'b0, 1'b0, 0, "dc");
    do_frame(1'b1, 1'b0, 0, "dc_sc");
    for (int i = 0; i < N; i++) begin
      xr[i] = (i % 2 == 0) ? 1000 : -1000;
      xi[i] = 0;
    end
    do_frame(1'b0, 1'b0, 0, "nyq");
    for (int i = 0; i < N; i++) begin
      xr[i] = (i % 4 == 0) ? 1000 : (i % 4 == 2) ? -1000 : 0;
      xi[i] = (i % 4 == 1) ? 1000 : (i % 4 == 3) ? -1000 : 0;
    end
    do_frame(1'b0, 1'b0, 0, "quarter");
    fill(8000, 0, 8000, 0);
    do_frame(1'b0, 1'b0, 0, "ovf");
    fill(1, 0, 0, 0);
    do_frame(1'b0, 1'b0, 0, "ovf_clear");

    for (int i = 0; i < N; i++) begin
      xr[i] = int'($urandom_range(0, 4000)) - 2000;
      xi[i] = int'($urandom_range(0, 4000)) - 2000;
    end
    do_frame(1'b0, 1'b0, 1, "bp");
    for (int i = 0; i < N; i++) begin
      xr[i] = int'($urandom_range(0, 8000)) - 4000;
      xi[i] = int'($urandom_range(0, 8000)) - 4000;
    end
    do_frame(1'b1, 1'b1, 0, "hold");
    fill(1000, 0, 0, 0);
    do_frame(1'b0, 1'b0, 0, "after_hold");

    // Abort in the middle of the compute phase.
    fill(1000, 0, 0, 0);
    send_frame(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort_valid", int'(link.out_valid), 0);
    check("abort_busy", int'(link.busy), 0);
    check("abort_inrdy", int'(link.in_ready), 0);
    @(posedge clk); #1;
    check("abort_inrdy_next", int'(link.in_ready), 1);
    fill(1000, 0, 0, 0);
    do_frame(1'b0, 1'b0, 0, "post_abort");

    for (int f = 0; f < 8; f++) begin
      int lim = (f % 2 == 0) ? 32767 : 6000;
      for (int i = 0; i < N; i++) begin
        xr[i] = int'($urandom_range(0, 2 * lim)) - lim;
        xi[i] = int'($urandom_range(0, 2 * lim)) - lim;
      end
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f % 3,
               $sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
